// File: rtl/operand_fetch.sv
// operand_fetch: read-side client of a 2R/1W register file.
//   Issues rs/rt read selectors, captures the registered read data one cycle
//   later (stage S1) and queues complete operand sets in an in-order output
//   FIFO towards execute. The register-file write port is snooped so that any
//   write the registered read missed is forwarded, both into S1 and into every
//   entry still waiting in the FIFO.
// Ports:
//   clock, reset_n                  clock, asynchronous active-low reset
//   in_valid/in_ready               fetch request handshake from decode
//   in_rs, in_rt, in_tag            source indices and opaque payload
//   rf_sel_out1/2                   read selectors (combinational copy of in_rs/in_rt)
//   rf_value_out1/2                 read data, valid the cycle after the selector edge
//   wb_enable, wb_sel, wb_value     snooped register-file write port
//   out_valid/out_ready             operand handshake towards execute
//   out_rs_value, out_rt_value,
//   out_tag                         FIFO head contents
// Build option:
//   OPFETCH_STATS_EN adds stat_fwd_count / stat_stall_count outputs.
module operand_fetch #(
    parameter int unsigned TAG_W     = 8,
    parameter int unsigned OUT_DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [TAG_W-1:0] in_tag,
    output logic [4:0]       rf_sel_out1,
    output logic [4:0]       rf_sel_out2,
    input  logic [31:0]      rf_value_out1,
    input  logic [31:0]      rf_value_out2,
    input  logic             wb_enable,
    input  logic [4:0]       wb_sel,
    input  logic [31:0]      wb_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_rs_value,
    output logic [31:0]      out_rt_value,
    output logic [TAG_W-1:0] out_tag
`ifdef OPFETCH_STATS_EN
    ,
    output logic [31:0]      stat_fwd_count,
    output logic [31:0]      stat_stall_count
`endif
);

    localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [31:0]      rs_val;
        logic [31:0]      rt_val;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // A write hits an index only when enabled and not targeting r0.
    function automatic logic snoop_hit(input logic en, input logic [4:0] sel,
                                       input logic [4:0] idx);
        return en && (sel != 5'd0) && (sel == idx);
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Stage S1 state
    logic             s1_valid_q, s1_valid_d;
    logic [4:0]       s1_rs_q, s1_rs_d;
    logic [4:0]       s1_rt_q, s1_rt_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s1_hit1_q, s1_hit1_d;
    logic             s1_hit2_q, s1_hit2_d;
    logic [31:0]      s1_fwd_q, s1_fwd_d;

    // Output FIFO state
    entry_t                 fifo_q [OUT_DEPTH];
    entry_t                 fifo_d [OUT_DEPTH];
    logic [OUT_DEPTH-1:0]   vld_q, vld_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic             deq_c;
    logic             accept_c;
    logic [OCC_W-1:0] occ_c;
    entry_t           push_c;

    assign rf_sel_out1  = in_rs;
    assign rf_sel_out2  = in_rt;
    assign out_valid    = (count_q != '0);
    assign out_rs_value = fifo_q[rd_ptr_q].rs_val;
    assign out_rt_value = fifo_q[rd_ptr_q].rt_val;
    assign out_tag      = fifo_q[rd_ptr_q].tag;

    // Occupancy after this edge must leave room for whatever S1 pushes next.
    always_comb begin : occupancy
        deq_c    = out_valid && out_ready;
        occ_c    = OCC_W'(count_q) + OCC_W'(s1_valid_q) - OCC_W'(deq_c);
        in_ready = (occ_c < OCC_W'(OUT_DEPTH));
        accept_c = in_valid && in_ready;
    end

    // S1 capture; a write on the accept edge is missed by the RF read, so keep it.
    always_comb begin : s1_next
        s1_valid_d = accept_c;
        s1_rs_d    = s1_rs_q;
        s1_rt_d    = s1_rt_q;
        s1_tag_d   = s1_tag_q;
        s1_hit1_d  = s1_hit1_q;
        s1_hit2_d  = s1_hit2_q;
        s1_fwd_d   = s1_fwd_q;
        if (accept_c) begin
            s1_rs_d   = in_rs;
            s1_rt_d   = in_rt;
            s1_tag_d  = in_tag;
            s1_hit1_d = snoop_hit(wb_enable, wb_sel, in_rs);
            s1_hit2_d = snoop_hit(wb_enable, wb_sel, in_rt);
            s1_fwd_d  = wb_value;
        end
    end

    // Entry pushed from S1: a write on the push edge beats the latched one.
    always_comb begin : push_entry
        push_c     = '0;
        push_c.rs  = s1_rs_q;
        push_c.rt  = s1_rt_q;
        push_c.tag = s1_tag_q;
        if (s1_rs_q == 5'd0)                          push_c.rs_val = '0;
        else if (snoop_hit(wb_enable, wb_sel, s1_rs_q)) push_c.rs_val = wb_value;
        else if (s1_hit1_q)                           push_c.rs_val = s1_fwd_q;
        else                                          push_c.rs_val = rf_value_out1;
        if (s1_rt_q == 5'd0)                          push_c.rt_val = '0;
        else if (snoop_hit(wb_enable, wb_sel, s1_rt_q)) push_c.rt_val = wb_value;
        else if (s1_hit2_q)                           push_c.rt_val = s1_fwd_q;
        else                                          push_c.rt_val = rf_value_out2;
    end

    // FIFO: in-place forwarding for resident entries, then pop, then push.
    always_comb begin : fifo_next
        fifo_d   = fifo_q;
        vld_d    = vld_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        for (int i = 0; i < OUT_DEPTH; i++) begin
            if (vld_q[i] && !(deq_c && (rd_ptr_q == PTR_W'(i)))) begin
                if (snoop_hit(wb_enable, wb_sel, fifo_q[i].rs)) fifo_d[i].rs_val = wb_value;
                if (snoop_hit(wb_enable, wb_sel, fifo_q[i].rt)) fifo_d[i].rt_val = wb_value;
            end
        end
        if (deq_c) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = next_ptr(rd_ptr_q);
        end
        if (s1_valid_q) begin
            fifo_d[wr_ptr_q] = push_c;
            vld_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d         = next_ptr(wr_ptr_q);
        end
        count_d = count_q + CNT_W'(s1_valid_q) - CNT_W'(deq_c);
    end

    always_ff @(posedge clock or negedge reset_n) begin : state_regs
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_rs_q    <= '0;
            s1_rt_q    <= '0;
            s1_tag_q   <= '0;
            s1_hit1_q  <= 1'b0;
            s1_hit2_q  <= 1'b0;
            s1_fwd_q   <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) fifo_q[i] <= '0;
            vld_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_rs_q    <= s1_rs_d;
            s1_rt_q    <= s1_rt_d;
            s1_tag_q   <= s1_tag_d;
            s1_hit1_q  <= s1_hit1_d;
            s1_hit2_q  <= s1_hit2_d;
            s1_fwd_q   <= s1_fwd_d;
            for (int i = 0; i < OUT_DEPTH; i++) fifo_q[i] <= fifo_d[i];
            vld_q      <= vld_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

`ifdef OPFETCH_STATS_EN
    logic [31:0] fwd_cnt_q, fwd_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_inc_c;

    // Operands forwarded this edge: S1 push (latched or live write) plus resident entries.
    always_comb begin : stats_next
        fwd_inc_c = '0;
        if (s1_valid_q) begin
            if (s1_hit1_q || snoop_hit(wb_enable, wb_sel, s1_rs_q)) fwd_inc_c = fwd_inc_c + 32'd1;
            if (s1_hit2_q || snoop_hit(wb_enable, wb_sel, s1_rt_q)) fwd_inc_c = fwd_inc_c + 32'd1;
        end
        for (int i = 0; i < OUT_DEPTH; i++) begin
            if (vld_q[i] && !(deq_c && (rd_ptr_q == PTR_W'(i)))) begin
                if (snoop_hit(wb_enable, wb_sel, fifo_q[i].rs)) fwd_inc_c = fwd_inc_c + 32'd1;
                if (snoop_hit(wb_enable, wb_sel, fifo_q[i].rt)) fwd_inc_c = fwd_inc_c + 32'd1;
            end
        end
        fwd_cnt_d   = fwd_cnt_q + fwd_inc_c;
        stall_cnt_d = stall_cnt_q + 32'(in_valid && !in_ready);
    end

    always_ff @(posedge clock or negedge reset_n) begin : stats_regs
        if (!reset_n) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            fwd_cnt_q   <= fwd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_fwd_count   = fwd_cnt_q;
    assign stat_stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed and randomized bench for operand_fetch.
//   The bench owns a behavioural register file (registered read, write after
//   read) and an architectural reference: every queued operand must equal the
//   current architectural value of its register while it waits, entries appear
//   one edge after acceptance and leave in order, and a request is accepted
//   only when total occupancy after this edge's pop is below OUT_DEPTH.
module tb_operand_fetch;

    localparam int unsigned TAG_W     = 8;
    localparam int unsigned OUT_DEPTH = 2;

    logic             clock;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_rs;
    logic [4:0]       in_rt;
    logic [TAG_W-1:0] in_tag;
    logic [4:0]       rf_sel_out1;
    logic [4:0]       rf_sel_out2;
    logic [31:0]      rf_value_out1;
    logic [31:0]      rf_value_out2;
    logic             wb_enable;
    logic [4:0]       wb_sel;
    logic [31:0]      wb_value;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_rs_value;
    logic [31:0]      out_rt_value;
    logic [TAG_W-1:0] out_tag;
`ifdef OPFETCH_STATS_EN
    logic [31:0]      stat_fwd_count;
    logic [31:0]      stat_stall_count;
`endif

    operand_fetch #(.TAG_W(TAG_W), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rs         (in_rs),
        .in_rt         (in_rt),
        .in_tag        (in_tag),
        .rf_sel_out1   (rf_sel_out1),
        .rf_sel_out2   (rf_sel_out2),
        .rf_value_out1 (rf_value_out1),
        .rf_value_out2 (rf_value_out2),
        .wb_enable     (wb_enable),
        .wb_sel        (wb_sel),
        .wb_value      (wb_value),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rs_value  (out_rs_value),
        .out_rt_value  (out_rt_value),
        .out_tag       (out_tag)
`ifdef OPFETCH_STATS_EN
        ,
        .stat_fwd_count   (stat_fwd_count),
        .stat_stall_count (stat_stall_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [7:0] tag;
        int         vis;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] regs [32];
    ent_t        q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] arch(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : regs[r];
    endfunction

    // One clock: check head, drive inputs, check handshake, advance model.
    task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [7:0] tag, input logic ordy, input logic we,
                        input logic [4:0] ws, input logic [31:0] wv);
        logic        exp_v;
        logic        exp_rdy;
        logic        deq;
        logic        acc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        ent_t        e;
        exp_v = (q.size() > 0) && (q[0].vis <= cyc);
        chk("out_valid", 32'(out_valid), 32'(exp_v));
        if (exp_v) begin
            chk("out_rs_value", out_rs_value, arch(q[0].rs));
            chk("out_rt_value", out_rt_value, arch(q[0].rt));
            chk("out_tag", 32'(out_tag), 32'(q[0].tag));
        end
        in_valid  = v;
        in_rs     = rs;
        in_rt     = rt;
        in_tag    = tag;
        out_ready = ordy;
        wb_enable = we;
        wb_sel    = ws;
        wb_value  = wv;
        #1;
        deq     = exp_v && ordy;
        exp_rdy = ((q.size() - (deq ? 1 : 0)) < int'(OUT_DEPTH));
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("rf_sel_out1", 32'(rf_sel_out1), 32'(rs));
        chk("rf_sel_out2", 32'(rf_sel_out2), 32'(rt));
        acc = v && exp_rdy;
        rd1 = arch(rs);
        rd2 = arch(rt);
        @(posedge clock);
        #1;
        rf_value_out1 = rd1;
        rf_value_out2 = rd2;
        cyc++;
        if (deq) void'(q.pop_front());
        if (acc) begin
            e.rs  = rs;
            e.rt  = rt;
            e.tag = tag;
            e.vis = cyc + 1;
            q.push_back(e);
        end
        if (we && (ws != 5'd0)) regs[ws] = wv;
        @(negedge clock);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 5'd0, 5'd0, 8'd0, ordy, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) idle(1'b1);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wb_enable = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_rs", out_rs_value, 32'd0);
        chk("rst_out_rt", out_rt_value, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        q.delete();
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic       rv;
        logic       ro;
        logic       rw;
        logic [4:0] r1;
        logic [4:0] r2;
        logic [4:0] r3;

        reset_n       = 1'b0;
        in_valid      = 1'b0;
        in_rs         = '0;
        in_rt         = '0;
        in_tag        = '0;
        out_ready     = 1'b0;
        wb_enable     = 1'b0;
        wb_sel        = '0;
        wb_value      = '0;
        rf_value_out1 = '0;
        rf_value_out2 = '0;
        regs[0]       = 32'd0;
        for (int i = 1; i < 32; i++) regs[i] = $urandom;

        @(negedge clock);
        do_reset();

        // r5 = 0x1234, then fetch rs=5 rt=0 tag=3
        step(1'b0, 5'd0, 5'd0, 8'd0, 1'b0, 1'b1, 5'd5, 32'h0000_1234);
        step(1'b1, 5'd5, 5'd0, 8'h03, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("lat_not_yet_valid", 32'(out_valid), 32'd0);
        idle(1'b0);
        chk("r5_out_valid", 32'(out_valid), 32'd1);
        chk("r5_out_rs", out_rs_value, 32'h0000_1234);
        chk("r5_out_rt", out_rt_value, 32'd0);
        chk("r5_out_tag", 32'(out_tag), 32'h03);
        drain();

        // write r7 on the accept edge, rs=rt=7
        step(1'b1, 5'd7, 5'd7, 8'h11, 1'b1, 1'b1, 5'd7, 32'hAAAA_5555);
        idle(1'b0);
        chk("fwd_a_rs", out_rs_value, 32'hAAAA_5555);
        chk("fwd_a_rt", out_rt_value, 32'hAAAA_5555);
        drain();

        // write r7 on the push edge
        step(1'b1, 5'd7, 5'd2, 8'h12, 1'b1, 1'b0, 5'd0, 32'd0);
        step(1'b0, 5'd0, 5'd0, 8'd0, 1'b0, 1'b1, 5'd7, 32'h0BAD_F00D);
        chk("fwd_b_rs", out_rs_value, 32'h0BAD_F00D);
        drain();

        // backpressure: two held, third stalls, in-place forwarding
        step(1'b1, 5'd9, 5'd9, 8'h21, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 5'd9, 5'd9, 8'h22, 1'b0, 1'b0, 5'd0, 32'd0);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        @(negedge clock);
        step(1'b1, 5'd9, 5'd9, 8'h23, 1'b0, 1'b1, 5'd9, 32'h0000_0055);
        idle(1'b0);
        chk("held_head_rs", out_rs_value, 32'h0000_0055);
        chk("held_head_tag", 32'(out_tag), 32'h21);
        step(1'b1, 5'd9, 5'd9, 8'h23, 1'b1, 1'b0, 5'd0, 32'd0);
        chk("held_second_rs", out_rs_value, 32'h0000_0055);
        chk("held_second_tag", 32'(out_tag), 32'h22);
        drain();

        // r0 write ignored; r0 reads zero
        step(1'b1, 5'd0, 5'd0, 8'h30, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
        idle(1'b0);
        chk("r0_out_rs", out_rs_value, 32'd0);
        chk("r0_out_rt", out_rt_value, 32'd0);
        drain();

        // back-to-back, one op per cycle
        for (int i = 0; i < 8; i++)
            step(1'b1, 5'(i + 1), 5'(i + 2), 8'(8'h40 + i), 1'b1, 1'b0, 5'd0, 32'd0);
        drain();

        // reset with work in flight
        step(1'b1, 5'd3, 5'd4, 8'h50, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 5'd4, 5'd3, 8'h51, 1'b0, 1'b0, 5'd0, 32'd0);
        do_reset();
        idle(1'b1);
        idle(1'b1);

        // randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            ro = ($urandom_range(0, 2) != 0);
            rw = ($urandom_range(0, 1) != 0);
            r1 = 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 7));
            r3 = 5'($urandom_range(0, 7));
            step(rv, r1, r2, 8'($urandom), ro, rw, r3, $urandom);
            if (i == 250) do_reset();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
